// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port-B arbiter: requester ids,
// FSM states and the read-return tag carried alongside each BRAM read.
package bram_arb_pkg;

  localparam int NREQ = 3;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_LOAD  = 2'd0;
  localparam req_id_t REQ_STORE = 2'd1;
  localparam req_id_t REQ_HOST  = 2'd2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  function automatic logic [NREQ-1:0] id_onehot(input req_id_t id);
    return {{(NREQ-1){1'b0}}, 1'b1} << id;
  endfunction

  function automatic req_id_t next_ptr(input req_id_t id);
    return (id == REQ_HOST) ? REQ_LOAD : id + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin picker: the search starts at ptr_i and
// wraps modulo NREQ; the first requester found wins.
module rr_arbiter
  import bram_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [1:0]      winner_o,
  output logic            any_o
);

  logic [2:0] sum_s;
  logic [1:0] idx_s;
  logic       take_s;
  logic       found_s;

  // priority search from the pointer, first hit masks all later candidates
  always_comb begin
    gnt_o    = '0;
    winner_o = ptr_i;
    found_s  = 1'b0;
    sum_s    = 3'd0;
    idx_s    = 2'd0;
    take_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s         = {1'b0, ptr_i} + 3'(k);
      idx_s         = (sum_s >= 3'd3) ? 2'(sum_s - 3'd3) : sum_s[1:0];
      take_s        = req_i[idx_s] & ~found_s;
      gnt_o[idx_s]  = gnt_o[idx_s] | take_s;
      winner_o      = take_s ? idx_s : winner_o;
      found_s       = found_s | take_s;
    end
    any_o = found_s;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port B between load, store and host requesters with round-robin
// arbitration, optional burst lock, registered issue and tagged read return.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        REQ_WE,
  input  logic [NREQ-1:0]        REQ_LOCK,
  input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NREQ*DATA_W-1:0] REQ_WDATA,
  input  logic [NREQ*4-1:0]      REQ_BE,
  output logic [NREQ-1:0]        GNT,
  output logic [NREQ-1:0]        RVALID,
  output logic [DATA_W-1:0]      RDATA,
  output logic [ADDR_W-1:0]      addrb,
  output logic [DATA_W-1:0]      dinb,
  input  logic [DATA_W-1:0]      doutb,
  output logic                   enb,
  output logic [3:0]             web,
  output logic                   BUSY
);

  arb_state_t        state_q, state_d;
  req_id_t           lock_id_q, lock_id_d;
  req_id_t           ptr_q, ptr_d;
  logic [NREQ-1:0]   rr_gnt_s;
  req_id_t           rr_win_s;
  logic              rr_any_s;
  logic [NREQ-1:0]   gnt_s;
  req_id_t           sel_id_s;
  logic              issue_s;
  logic              enb_q;
  logic [3:0]        web_q;
  logic [ADDR_W-1:0] addrb_q;
  logic [DATA_W-1:0] dinb_q;
  logic [NREQ-1:0]   rvalid_q;
  rd_tag_t           tag_q [RD_LAT];
  logic              busy_s;

  rr_arbiter u_rr (
    .req_i    (REQ),
    .ptr_i    (ptr_q),
    .gnt_o    (rr_gnt_s),
    .winner_o (rr_win_s),
    .any_o    (rr_any_s)
  );

  // arbitration FSM next state and the combinational grant
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    ptr_d     = ptr_q;
    gnt_s     = '0;
    sel_id_s  = rr_win_s;
    case (state_q)
      ARB: begin
        gnt_s = rr_gnt_s;
        if (rr_any_s) begin
          ptr_d = next_ptr(rr_win_s);
          if (REQ_LOCK[rr_win_s]) begin
            state_d   = LOCKED;
            lock_id_d = rr_win_s;
          end else begin
            state_d = ARB;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      LOCKED: begin
        sel_id_s = lock_id_q;
        gnt_s    = REQ[lock_id_q] ? id_onehot(lock_id_q) : '0;
        if (!REQ[lock_id_q] || !REQ_LOCK[lock_id_q]) begin
          state_d = ARB;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // grants are suppressed while reset is held so nothing is consumed
  assign GNT     = gnt_s & {NREQ{RSTN}};
  assign issue_s = |GNT;

  // FSM state, registered BRAM issue and the read-return tag pipeline
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ARB;
      lock_id_q <= REQ_LOAD;
      ptr_q     <= REQ_LOAD;
      enb_q     <= 1'b0;
      web_q     <= 4'h0;
      addrb_q   <= '0;
      dinb_q    <= '0;
      rvalid_q  <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      ptr_q     <= ptr_d;
      enb_q     <= issue_s;
      web_q     <= (issue_s && REQ_WE[sel_id_s]) ? REQ_BE[sel_id_s*4 +: 4] : 4'h0;
      if (issue_s) begin
        addrb_q <= REQ_ADDR[sel_id_s*ADDR_W +: ADDR_W];
        dinb_q  <= REQ_WDATA[sel_id_s*DATA_W +: DATA_W];
      end
      tag_q[0] <= '{valid: issue_s & ~REQ_WE[sel_id_s], id: sel_id_s};
      for (int k = 1; k < RD_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      rvalid_q <= tag_q[RD_LAT-1].valid ? id_onehot(tag_q[RD_LAT-1].id) : '0;
    end
  end

  // busy while any read is still travelling or a burst holds the port
  always_comb begin
    busy_s = (state_q == LOCKED);
    for (int k = 0; k < RD_LAT; k++) begin
      busy_s = busy_s | tag_q[k].valid;
    end
  end

  assign enb    = enb_q;
  assign web    = web_q;
  assign addrb  = addrb_q;
  assign dinb   = dinb_q;
  assign RVALID = rvalid_q;
  assign RDATA  = (|rvalid_q) ? doutb : '0;
  assign BUSY   = busy_s;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: a write-first BRAM model behind the arbiter and a
// scoreboard queue of expected read returns (id, data, arrival cycle).
module tb_bram_port_arbiter;

  localparam int RD_LAT = 2;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [2:0]  REQ, REQ_WE, REQ_LOCK;
  logic [95:0] REQ_ADDR, REQ_WDATA;
  logic [11:0] REQ_BE;
  logic [2:0]  GNT, RVALID;
  logic [31:0] RDATA, addrb, dinb, doutb;
  logic        enb, BUSY;
  logic [3:0]  web;

  bram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_LOCK(REQ_LOCK),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE),
    .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .addrb(addrb), .dinb(dinb),
    .doutb(doutb), .enb(enb), .web(web), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // write-first BRAM model with RD_LAT cycles from the enb cycle to doutb
  logic [31:0] bmem  [256];
  logic [31:0] bpipe [RD_LAT];
  logic        loaded = 1'b0;
  always @(posedge CLK) begin
    if (!loaded) begin
      bmem[8'h10] <= 32'hDEADBEEF;
      bmem[8'h20] <= 32'h0000_0000;
      bmem[8'h30] <= 32'hFFFF_FFFF;
      loaded      <= 1'b1;
    end else if (enb) begin
      bmem[addrb[7:0]] <= merge(bmem[addrb[7:0]], dinb, web);
      bpipe[0]         <= merge(bmem[addrb[7:0]], dinb, web);
    end
    for (int k = 1; k < RD_LAT; k++) bpipe[k] <= bpipe[k-1];
  end
  assign doutb = bpipe[RD_LAT-1];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] ref_mem [256];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        prev_en;
  logic [31:0] prev_addr, prev_din;
  logic [3:0]  prev_web;

  // return monitor: every RVALID must match the head of the scoreboard
  always @(negedge CLK) begin
    if (RSTN && RVALID != 3'b000) begin
      if (sbq.size() == 0) begin
        chk("rv_spurious", {61'd0, RVALID}, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rv_id", {61'd0, RVALID}, {61'd0, 3'b001 << e.id});
        chk("rdata", {32'd0, RDATA}, {32'd0, e.data});
        chk("rv_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // one arbitration cycle: drive, check grant and last cycle's issue, predict
  task automatic cycle(input logic [2:0] req, input logic [2:0] we,
                       input logic [2:0] lock, input logic [2:0] exp_gnt);
    int id;
    REQ       = req;
    REQ_WE    = we;
    REQ_LOCK  = lock;
    REQ_ADDR  = {addr[2], addr[1], addr[0]};
    REQ_WDATA = {wdata[2], wdata[1], wdata[0]};
    REQ_BE    = {be[2], be[1], be[0]};
    @(negedge CLK);
    chk("gnt", {61'd0, GNT}, {61'd0, exp_gnt});
    chk("enb", {63'd0, enb}, {63'd0, prev_en});
    if (prev_en) begin
      chk("addrb", {32'd0, addrb}, {32'd0, prev_addr});
      chk("dinb", {32'd0, dinb}, {32'd0, prev_din});
      chk("web", {60'd0, web}, {60'd0, prev_web});
    end else begin
      chk("web_idle", {60'd0, web}, 64'd0);
    end
    prev_en = |exp_gnt;
    id = 0;
    for (int i = 0; i < 3; i++) if (exp_gnt[i]) id = i;
    if (prev_en) begin
      prev_addr = addr[id];
      prev_din  = wdata[id];
      prev_web  = we[id] ? be[id] : 4'h0;
      if (we[id]) begin
        ref_mem[addr[id][7:0]] = merge(ref_mem[addr[id][7:0]], wdata[id], be[id]);
      end else begin
        sbq.push_back('{id: 2'(id), data: ref_mem[addr[id][7:0]], at: cyc + 1 + RD_LAT});
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(3'b000, 3'b000, 3'b000, 3'b000);
  endtask

  task automatic do_reset();
    REQ  = 3'b000;
    RSTN = 1'b0;
    prev_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    ref_mem[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h20] = 32'h0000_0000;
    ref_mem[8'h30] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 32'h10;
      wdata[i] = 32'h0;
      be[i]    = 4'hF;
    end
    prev_en   = 1'b0;
    prev_addr = 32'd0;
    prev_din  = 32'd0;
    prev_web  = 4'h0;
    REQ = 3'b111; REQ_WE = 3'b000; REQ_LOCK = 3'b000;
    REQ_ADDR = '0; REQ_WDATA = '0; REQ_BE = '0;
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt", {61'd0, GNT}, 64'd0);
    chk("rst_rvalid", {61'd0, RVALID}, 64'd0);
    chk("rst_enb", {63'd0, enb}, 64'd0);
    chk("rst_web", {60'd0, web}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    chk("rst_addrb", {32'd0, addrb}, 64'd0);
    chk("rst_dinb", {32'd0, dinb}, 64'd0);
    chk("rst_rdata", {32'd0, RDATA}, 64'd0);
    RSTN = 1'b1;
    REQ  = 3'b000;

    // single read
    addr[0] = 32'h10;
    cycle(3'b001, 3'b000, 3'b000, 3'b001);
    idle(4);
    chk("busy_drained", {63'd0, BUSY}, 64'd0);

    // write then read same address; pointer is at store
    addr[1] = 32'h20; wdata[1] = 32'h12345678; be[1] = 4'hF;
    cycle(3'b010, 3'b010, 3'b000, 3'b010);
    addr[0] = 32'h20;
    cycle(3'b001, 3'b000, 3'b000, 3'b001);
    idle(4);

    // partial write then read-back
    addr[1] = 32'h30; wdata[1] = 32'hAAAABBBB; be[1] = 4'h3;
    cycle(3'b010, 3'b010, 3'b000, 3'b010);
    addr[0] = 32'h30;
    cycle(3'b001, 3'b000, 3'b000, 3'b001);
    idle(4);

    // all three reading continuously from reset
    do_reset();
    addr[0] = 32'h10; addr[1] = 32'h20; addr[2] = 32'h30;
    cycle(3'b111, 3'b000, 3'b000, 3'b001);
    cycle(3'b111, 3'b000, 3'b000, 3'b010);
    cycle(3'b111, 3'b000, 3'b000, 3'b100);
    cycle(3'b111, 3'b000, 3'b000, 3'b001);
    cycle(3'b111, 3'b000, 3'b000, 3'b010);
    cycle(3'b111, 3'b000, 3'b000, 3'b100);
    idle(4);

    // host lock burst of four while load waits
    addr[2] = 32'h10;
    cycle(3'b100, 3'b000, 3'b100, 3'b100);
    cycle(3'b101, 3'b000, 3'b100, 3'b100);
    chk("busy_locked", {63'd0, BUSY}, 64'd1);
    cycle(3'b101, 3'b000, 3'b100, 3'b100);
    cycle(3'b101, 3'b000, 3'b000, 3'b100);
    cycle(3'b101, 3'b000, 3'b000, 3'b001);
    cycle(3'b101, 3'b000, 3'b000, 3'b100);
    idle(4);

    // single unlocked requester granted every cycle, then a dropped request
    cycle(3'b010, 3'b000, 3'b000, 3'b010);
    cycle(3'b010, 3'b000, 3'b000, 3'b010);
    cycle(3'b010, 3'b000, 3'b000, 3'b010);
    cycle(3'b101, 3'b000, 3'b000, 3'b100);
    idle(4);

    // reset one cycle after two reads issue
    cycle(3'b001, 3'b000, 3'b000, 3'b001);
    cycle(3'b010, 3'b000, 3'b000, 3'b010);
    REQ  = 3'b111;
    RSTN = 1'b0;
    #1;
    chk("mid_rst_enb", {63'd0, enb}, 64'd0);
    chk("mid_rst_gnt", {61'd0, GNT}, 64'd0);
    chk("mid_rst_busy", {63'd0, BUSY}, 64'd0);
    chk("mid_rst_addrb", {32'd0, addrb}, 64'd0);
    sbq.delete();
    prev_en = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    REQ  = 3'b000;
    idle(5);
    cycle(3'b111, 3'b000, 3'b000, 3'b001);
    idle(4);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
